fp_mul_round: RTL and testbench
===============================

Name: fp_mul_round

Overview:
- Post-multiply stage of the FPU single-precision multiply path.
- Consumes the raw 64-bit integer significand product from the shift-add multiplier (24-bit significands with hidden bit, so only prod[47:0] is meaningful) together with the original IEEE-754 operands.
- Classifies special operands, normalizes, rounds round-to-nearest-even and packs a 32-bit IEEE-754 result with exception flags.
- Uses a valid/ready handshake on both sides.

Parameters:
- EXP_BIAS, 127, exponent bias applied to ea+eb.
- PROD_W, 64, width of the product input; bits above 47 are ignored.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  op_a, op_b and prod are valid; top level asserts it once the multiplier's completion flag is high.
- in_ready  output  1  block can accept a new operation.
- op_a  input  32  IEEE-754 operand A.
- op_b  input  32  IEEE-754 operand B.
- prod  input  PROD_W  significand product {1,fa}*{1,fb}.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  packed IEEE-754 product.
- flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, result=0, flags=0.
  - Any in-flight operation is discarded.
  - Outputs stay at reset values until a new transfer completes.
- FSM states: IDLE, NORM, ROUND, DONE.
  - IDLE: in_ready=1. At a clk edge with in_valid=1, capture op_a, op_b and prod[47:0], then go to NORM.
  - NORM: classify operands and normalize (below), then go to ROUND.
  - ROUND: round, detect exceptions, register result/flags, then go to DONE.
  - DONE: out_valid=1, result/flags held stable. At an edge with out_ready=1, go to IDLE and drop out_valid.
- in_ready=0 in every state except IDLE. No overlap between operations; in_valid is ignored outside IDLE.
- Latency: input accepted at edge N; out_valid rises after edge N+3. This is fixed for all inputs, including special cases.
- Sign: s = sa XOR sb, applied to every result including zero and inf. Canonical NaN is always positive.
- Classification (exponent e, fraction f):
  - e=0 is zero; denormal inputs are flushed to zero.
  - e=255 with f=0 is inf; e=255 with f!=0 is NaN.
  - sNaN means f[22]=0.
- Special-case priority:
  1. Either operand NaN -> result 0x7FC00000; invalid=1 only if either operand is sNaN.
  2. zero*inf -> 0x7FC00000, invalid=1.
  3. Either operand inf -> {s,0xFF,0}.
  4. Either operand zero -> {s,0,0}.
  - All special cases: prod ignored; inexact/overflow/underflow=0.
- Normalization, with exp held as a 10-bit signed value:
  - prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=ea+eb-EXP_BIAS+1.
  - Otherwise: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=ea+eb-EXP_BIAS.
- Rounding (RNE):
  - Increment when guard & (sticky | mant[0]).
  - If the increment carries out of mant (mant=0x7FFFFF+1): mant=0, exp=exp+1.
  - inexact = guard | sticky.
- Exponent range, checked after rounding:
  - exp>=255 -> {s,0xFF,0}, overflow=1, inexact=1.
  - exp<=0 -> {s,0,0} (flush to zero, no denormal output), underflow=1, inexact=1.
  - Otherwise result = {s, exp[7:0], mant}.
- Simultaneous in_valid and out_ready in DONE: the DONE->IDLE transfer happens; the new input is taken on the following edge, when in_ready=1.
- Reset asserted in NORM/ROUND/DONE: immediate return to IDLE, out_valid=0. No result is ever emitted for the aborted operation.

Test Plan:
- Basic normal path: op_a=0x3FC00000, op_b=0x40000000, prod=0x600000000000 -> result 0x40400000, flags=0, out_valid rises 3 edges after acceptance.
- Rounding tie to even (round up): op_a=0x3FC00000, op_b=0x3F800001, prod=0x600000C00000 -> result 0x3FC00002, inexact=1. Negated op_a (0xBFC00000) -> 0xBFC00002.
- Overflow and underflow:
  - op_a=0x7F000000, op_b=0x40000000, prod=0x400000000000 -> 0x7F800000, flags=0b0101.
  - op_a=op_b=0x00800000, prod=0x400000000000 -> 0x00000000, flags=0b0011.
- Special cases:
  - op_a=0x00000000, op_b=0xFF800000 -> 0x7FC00000, flags=0b1000.
  - op_a=0x7FC00000, op_b=0x3F800000 -> 0x7FC00000, flags=0.
  - op_a=0x80000000, op_b=0x40000000 -> 0x80000000, flags=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> out_valid falls, in_ready=1 on the next cycle.
- Reset mid-operation: pull reset low asynchronously during ROUND -> out_valid=0, result=0, in_ready=1 immediately. After release, a fresh basic-path operation produces 0x40400000.

Source files
------------

// File: rtl/fp_mul_round.sv
// Post-multiply stage of the single-precision FPU multiply path:
// classifies operands, normalizes the 48-bit significand product, rounds
// to nearest-even and packs an IEEE-754 result with exception flags.
module fp_mul_round #(
   parameter int unsigned EXP_BIAS = 127,
   parameter int unsigned PROD_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic [3:0]        flags
);

   localparam int unsigned   SIG_W   = 48;
   localparam int unsigned   EXP_W   = 10;
   localparam logic [31:0]   QNAN    = 32'h7FC0_0000;
   localparam logic signed [EXP_W-1:0] EXP_MAX = 10'sd255;
   localparam logic signed [EXP_W-1:0] EXP_MIN = 10'sd0;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t                  state;
   logic [31:0]             a_q, b_q;
   logic [SIG_W-1:0]        p_q;

   // Normalized operation, held between NORM and ROUND
   logic                    sign_q;
   logic                    spec_q;
   logic [31:0]             spec_res_q;
   logic                    spec_inv_q;
   logic [22:0]             mant_q;
   logic                    guard_q;
   logic                    sticky_q;
   logic signed [EXP_W-1:0] exp_q;

   // Only the low 48 product bits carry significand information
   logic unused_prod_hi;
   assign unused_prod_hi = ^prod[PROD_W-1:SIG_W];

   // Operand classification, special-case selection and normalization
   logic                    sign_c;
   logic                    spec_c;
   logic [31:0]             spec_res_c;
   logic                    spec_inv_c;
   logic [22:0]             mant_c;
   logic                    guard_c;
   logic                    sticky_c;
   logic signed [EXP_W-1:0] exp_c;
   logic                    a_zero, a_inf, a_nan, a_snan;
   logic                    b_zero, b_inf, b_nan, b_snan;

   always_comb begin
      sign_c     = a_q[31] ^ b_q[31];
      a_zero     = (a_q[30:23] == 8'h00);
      b_zero     = (b_q[30:23] == 8'h00);
      a_inf      = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
      b_inf      = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
      a_nan      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
      b_nan      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
      a_snan     = a_nan & ~a_q[22];
      b_snan     = b_nan & ~b_q[22];
      spec_c     = 1'b1;
      spec_res_c = 32'h0;
      spec_inv_c = 1'b0;
      if (a_nan || b_nan) begin
         spec_res_c = QNAN;
         spec_inv_c = a_snan | b_snan;
      end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
         spec_res_c = QNAN;
         spec_inv_c = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_res_c = {sign_c, 8'hFF, 23'h0};
      end else if (a_zero || b_zero) begin
         spec_res_c = {sign_c, 31'h0};
      end else begin
         spec_c = 1'b0;
      end
      if (p_q[47]) begin
         mant_c   = p_q[46:24];
         guard_c  = p_q[23];
         sticky_c = |p_q[22:0];
      end else begin
         mant_c   = p_q[45:23];
         guard_c  = p_q[22];
         sticky_c = |p_q[21:0];
      end
      exp_c = EXP_W'(a_q[30:23]) + EXP_W'(b_q[30:23]) - EXP_W'(EXP_BIAS)
            + EXP_W'(p_q[47]);
   end

   // Round-to-nearest-even and exponent range check
   logic                    inc_c;
   logic                    carry_c;
   logic [22:0]             mant_r_c;
   logic signed [EXP_W-1:0] exp_r_c;
   logic                    inexact_c;

   always_comb begin
      inc_c               = guard_q & (sticky_q | mant_q[0]);
      {carry_c, mant_r_c} = 24'(mant_q) + 24'(inc_c);
      exp_r_c             = exp_q + EXP_W'(carry_c);
      inexact_c           = guard_q | sticky_q;
   end

   // Control FSM with all pipeline and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         result     <= 32'h0;
         flags      <= 4'h0;
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         p_q        <= '0;
         sign_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= 32'h0;
         spec_inv_q <= 1'b0;
         mant_q     <= 23'h0;
         guard_q    <= 1'b0;
         sticky_q   <= 1'b0;
         exp_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  p_q      <= prod[SIG_W-1:0];
                  in_ready <= 1'b0;
                  state    <= NORM;
               end
            end
            NORM: begin
               sign_q     <= sign_c;
               spec_q     <= spec_c;
               spec_res_q <= spec_res_c;
               spec_inv_q <= spec_inv_c;
               mant_q     <= mant_c;
               guard_q    <= guard_c;
               sticky_q   <= sticky_c;
               exp_q      <= exp_c;
               state      <= ROUND;
            end
            ROUND: begin
               if (spec_q) begin
                  result <= spec_res_q;
                  flags  <= {spec_inv_q, 3'b000};
               end else if (exp_r_c >= EXP_MAX) begin
                  result <= {sign_q, 8'hFF, 23'h0};
                  flags  <= 4'b0101;
               end else if (exp_r_c <= EXP_MIN) begin
                  result <= {sign_q, 31'h0};
                  flags  <= 4'b0011;
               end else begin
                  result <= {sign_q, exp_r_c[7:0], mant_r_c};
                  flags  <= {3'b000, inexact_c};
               end
               state <= DONE;
            end
            DONE: begin
               // First DONE cycle presents the result; handshake starts once valid
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_round.sv
// Directed bench for fp_mul_round: vector table plus handshake/reset sequences.
module tb_fp_mul_round;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [63:0] prod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_cmp;
   int n_err;

   fp_mul_round #(.EXP_BIAS(127), .PROD_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .prod      (prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      logic [31:0] res;
      logic [3:0]  fl;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present one operation once in_ready is seen; returns after the accept edge
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
      int ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      check("in_ready_wait", 32'(ok), 32'd1);
      op_a     = a;
      op_b     = b;
      prod     = p;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges from the accept edge until out_valid is observed
   task automatic wait_out(output int lat);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_a      = 32'h0;
      op_b      = 32'h0;
      prod      = 64'h0;

      vecs[0]  = '{"basic",        32'h3FC00000, 32'h40000000, 64'h600000000000, 32'h40400000, 4'b0000};
      vecs[1]  = '{"tie_up",       32'h3FC00000, 32'h3F800001, 64'h600000C00000, 32'h3FC00002, 4'b0001};
      vecs[2]  = '{"tie_up_neg",   32'hBFC00000, 32'h3F800001, 64'h600000C00000, 32'hBFC00002, 4'b0001};
      vecs[3]  = '{"overflow",     32'h7F000000, 32'h40000000, 64'h400000000000, 32'h7F800000, 4'b0101};
      vecs[4]  = '{"underflow",    32'h00800000, 32'h00800000, 64'h400000000000, 32'h00000000, 4'b0011};
      vecs[5]  = '{"zero_x_inf",   32'h00000000, 32'hFF800000, 64'h0,            32'h7FC00000, 4'b1000};
      vecs[6]  = '{"qnan",         32'h7FC00000, 32'h3F800000, 64'h400000000000, 32'h7FC00000, 4'b0000};
      vecs[7]  = '{"neg_zero",     32'h80000000, 32'h40000000, 64'h0,            32'h80000000, 4'b0000};
      vecs[8]  = '{"norm_top",     32'h3FC00000, 32'h3FC00000, 64'h900000000000, 32'h40100000, 4'b0000};
      vecs[9]  = '{"snan",         32'h7F800001, 32'h3F800000, 64'h400000000000, 32'h7FC00000, 4'b1000};
      vecs[10] = '{"inf_x_neg",    32'h7F800000, 32'hC0000000, 64'h0,            32'hFF800000, 4'b0000};
      vecs[11] = '{"tie_even",     32'h3F800000, 32'h3F800000, 64'h400000400000, 32'h3F800000, 4'b0001};
      vecs[12] = '{"round_carry",  32'h3F800000, 32'h3F800000, 64'h7FFFFFC00000, 32'h40000000, 4'b0001};

      // Reset values
      #12;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    result,         32'h0);
      check("rst_flags",     32'(flags),     32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven vectors
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].p);
         wait_out(lat);
         check({vecs[i].name, "_lat"},   32'(lat),   32'd3);
         check({vecs[i].name, "_res"},   result,     vecs[i].res);
         check({vecs[i].name, "_flags"}, 32'(flags), 32'(vecs[i].fl));
      end
      @(posedge clk);
      #1;
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_in_ready",  32'(in_ready),  32'd1);

      // Backpressure: result held, new input refused while DONE stalls
      out_ready = 1'b0;
      send(32'h3FC00000, 32'h40000000, 64'h600000000000);
      wait_out(lat);
      check("bp_lat", 32'(lat), 32'd3);
      op_a     = 32'h3FC00000;
      op_b     = 32'h3FC00000;
      prod     = 64'h900000000000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_result",    result,         32'h40400000);
         check("bp_flags",     32'(flags),     32'h0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready",  32'(in_ready),  32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_drop_valid", 32'(out_valid), 32'd0);
      check("bp_ready_back", 32'(in_ready),  32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp_accepted", 32'(in_ready), 32'd0);
      wait_out(lat);
      check("bp2_lat",   32'(lat),   32'd3);
      check("bp2_res",   result,     32'h40100000);
      check("bp2_flags", 32'(flags), 32'h0);

      // Asynchronous reset while the operation sits in ROUND
      send(32'h7F000000, 32'h40000000, 64'h400000000000);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_result",    result,         32'h0);
      check("arst_flags",     32'(flags),     32'h0);
      check("arst_in_ready",  32'(in_ready),  32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("arst_hold_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("arst_no_result", 32'(out_valid), 32'd0);
      end
      send(32'h3FC00000, 32'h40000000, 64'h600000000000);
      wait_out(lat);
      check("post_rst_lat",   32'(lat),   32'd3);
      check("post_rst_res",   result,     32'h40400000);
      check("post_rst_flags", 32'(flags), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
